// File: rtl/biquad_pkg.sv
// Shared widths, sample/coefficient types, FSM states and the output clamp helper
// for the direct-form-I biquad core.
package biquad_pkg;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 18;
  localparam int FRAC_BITS = 16;
  localparam int ACC_W     = 40;
  localparam int PROD_W    = DATA_W + COEF_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, MAC4, OUT} biquad_state_t;

  typedef struct packed {
    coef_t a0;
    coef_t a1;
    coef_t a2;
    coef_t b1;
    coef_t b2;
  } coef_set_t;

  typedef struct packed {
    sample_t value;
    logic    clamped;
  } sat_result_t;

  localparam sample_t SAMPLE_MAX = sample_t'((2 ** (DATA_W - 1)) - 1);
  localparam sample_t SAMPLE_MIN = sample_t'(-(2 ** (DATA_W - 1)));

  // Scale the Q2.16 accumulator back to sample units (floor) and clamp to the sample range.
  function automatic sat_result_t saturate(input acc_t acc);
    acc_t        r;
    sat_result_t res;
    r = acc >>> FRAC_BITS;
    if (r > acc_t'(SAMPLE_MAX)) begin
      res = '{value: SAMPLE_MAX, clamped: 1'b1};
    end else if (r < acc_t'(SAMPLE_MIN)) begin
      res = '{value: SAMPLE_MIN, clamped: 1'b1};
    end else begin
      res = '{value: r[DATA_W-1:0], clamped: 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for an asynchronous level followed by a rising-edge detector;
// pulse is high for one clock after the synchronized level goes 0 -> 1.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_prev;

  // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value of the one before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      meta      <= level;
      sync      <= meta;
      sync_prev <= sync;
    end
  end

  assign pulse = sync & ~sync_prev;

endmodule

// File: rtl/iir_biquad_core.sv
// Direct-form-I biquad for one audio channel, one shared 18x16 multiplier sequenced by an FSM.
// Define BIQUAD_SAT_EN to clamp the output and add the sat_flag port; otherwise the output wraps.
module iir_biquad_core
  import biquad_pkg::*;
(
  input  logic                     CLOCK_50,
  input  logic                     AUD_DACLRCK,
  input  logic                     new_sample,
  input  logic                     new_coefficients,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic signed [COEF_W-1:0] a0_load,
  input  logic signed [COEF_W-1:0] a1_load,
  input  logic signed [COEF_W-1:0] a2_load,
  input  logic signed [COEF_W-1:0] b1_load,
  input  logic signed [COEF_W-1:0] b2_load,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     out_valid,
  output logic                     busy
`ifdef BIQUAD_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  biquad_state_t state;
  biquad_state_t state_next;
  coef_set_t     coef;
  logic          coef_pend;
  logic          edge_p;
  sample_t       x0, x1, x2, y1, y2;
  acc_t          acc;
  coef_t         mul_a;
  sample_t       mul_b;
  prod_t         product;
  acc_t          product_ext;
  sample_t       y_new;

  pulse_sync_edge u_sample_sync (
    .clk   (CLOCK_50),
    .rst   (AUD_DACLRCK),
    .level (new_sample),
    .pulse (edge_p)
  );

  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) state <= IDLE;
    else             state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (edge_p) state_next = MAC0;
      end
      MAC0:    state_next = MAC1;
      MAC1:    state_next = MAC2;
      MAC2:    state_next = MAC3;
      MAC3:    state_next = MAC4;
      MAC4:    state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_a = coef.a0;
    mul_b = x0;
    case (state)
      MAC1: begin mul_a = coef.a1; mul_b = x1; end
      MAC2: begin mul_a = coef.a2; mul_b = x2; end
      MAC3: begin mul_a = coef.b1; mul_b = y1; end
      MAC4: begin mul_a = coef.b2; mul_b = y2; end
      default: ;
    endcase
  end

  assign product     = prod_t'(mul_a) * prod_t'(mul_b);
  assign product_ext = acc_t'(product);

`ifdef BIQUAD_SAT_EN
  sat_result_t sat_res;
  assign sat_res = saturate(acc);
  assign y_new   = sat_res.value;
`else
  // Floor-shift then keep the low DATA_W bits: two's-complement wrap on overflow.
  assign y_new = acc[FRAC_BITS +: DATA_W];
`endif

  always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      coef       <= '0;
      coef_pend  <= 1'b0;
      x0         <= '0;
      x1         <= '0;
      x2         <= '0;
      y1         <= '0;
      y2         <= '0;
      acc        <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
`ifdef BIQUAD_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
`ifdef BIQUAD_SAT_EN
      sat_flag  <= 1'b0;
`endif
      // Coefficients only move in IDLE; a request seen mid-step waits in coef_pend.
      if (state == IDLE) begin
        if (new_coefficients || coef_pend) begin
          coef      <= '{a0: a0_load, a1: a1_load, a2: a2_load, b1: b1_load, b2: b2_load};
          coef_pend <= 1'b0;
        end
        if (edge_p) x0 <= sample_in;
      end else if (new_coefficients) begin
        coef_pend <= 1'b1;
      end

      case (state)
        MAC0:       acc <= product_ext;
        MAC1, MAC2: acc <= acc + product_ext;
        MAC3, MAC4: acc <= acc - product_ext;
        OUT: begin
          sample_out <= y_new;
          out_valid  <= 1'b1;
          x2         <= x1;
          x1         <= x0;
          y2         <= y1;
          y1         <= y_new;
`ifdef BIQUAD_SAT_EN
          sat_flag   <= sat_res.clamped;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_core.sv
// Self-checking bench for iir_biquad_core: directed cases with hand-derived results plus
// randomized steps compared against an arithmetic difference-equation model.
module tb_iir_biquad_core;
  import biquad_pkg::*;

  logic    CLOCK_50 = 1'b0;
  logic    AUD_DACLRCK;
  logic    new_sample;
  logic    new_coefficients;
  sample_t sample_in;
  coef_t   a0_load, a1_load, a2_load, b1_load, b2_load;
  sample_t sample_out;
  logic    out_valid;
  logic    busy;
`ifdef BIQUAD_SAT_EN
  logic    sat_flag;
`endif

  iir_biquad_core dut (
    .CLOCK_50         (CLOCK_50),
    .AUD_DACLRCK      (AUD_DACLRCK),
    .new_sample       (new_sample),
    .new_coefficients (new_coefficients),
    .sample_in        (sample_in),
    .a0_load          (a0_load),
    .a1_load          (a1_load),
    .a2_load          (a2_load),
    .b1_load          (b1_load),
    .b2_load          (b2_load),
    .sample_out       (sample_out),
    .out_valid        (out_valid),
    .busy             (busy)
`ifdef BIQUAD_SAT_EN
    ,
    .sat_flag         (sat_flag)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: y = (a0*x0 + a1*x1 + a2*x2 - b1*y1 - b2*y2) floor-divided by 2^16.
  int m_c[5];
  int m_x1, m_x2, m_y1, m_y2;
  bit m_clamp;

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) m_c[i] = 0;
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0; m_clamp = 0;
  endfunction

  function automatic int model_step(input int x);
    longint sum, r;
    int     y;
    sum = longint'(m_c[0]) * x + longint'(m_c[1]) * m_x1 + longint'(m_c[2]) * m_x2
        - longint'(m_c[3]) * m_y1 - longint'(m_c[4]) * m_y2;
    r = sum >>> 16;
    m_clamp = 0;
`ifdef BIQUAD_SAT_EN
    if (r > 32767)       begin y = 32767;  m_clamp = 1; end
    else if (r < -32768) begin y = -32768; m_clamp = 1; end
    else                 y = int'(r);
`else
    y = int'(shortint'(r));
`endif
    m_x2 = m_x1; m_x1 = x; m_y2 = m_y1; m_y1 = y;
    return y;
  endfunction

  function automatic int rand_coef();
    coef_t c;
    c = coef_t'($urandom());
    return int'(c);
  endfunction

  function automatic int rand_sample();
    sample_t s;
    s = sample_t'($urandom());
    return int'(s);
  endfunction

  int late_set[5];
  int last_out;
  int last_sat;

  task automatic drive_loads(input int c0, input int c1, input int c2, input int c3, input int c4);
    a0_load = coef_t'(c0); a1_load = coef_t'(c1); a2_load = coef_t'(c2);
    b1_load = coef_t'(c3); b2_load = coef_t'(c4);
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3, input int c4);
    @(negedge CLOCK_50);
    drive_loads(c0, c1, c2, c3, c4);
    new_coefficients = 1'b1;
    @(negedge CLOCK_50);
    new_coefficients = 1'b0;
    m_c[0] = c0; m_c[1] = c1; m_c[2] = c2; m_c[3] = c3; m_c[4] = c4;
  endtask

  task automatic apply_reset();
    @(negedge CLOCK_50);
    AUD_DACLRCK = 1'b1; new_sample = 1'b0; new_coefficients = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    AUD_DACLRCK = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    model_reset();
  endtask

  // mode 0 plain, 1 second edge during MAC2, 2 coefficient request during MAC3,
  // 3 reset during MAC1, 4 coefficient load in the same IDLE cycle as the request.
  task automatic run_step(input int x, input int mode, output int first_valid, output int n_valid,
                          output int n_busy);
    @(negedge CLOCK_50);
    sample_in = sample_t'(x);
    new_sample = 1'b1;
    first_valid = 0; n_valid = 0; n_busy = 0;
    for (int e = 1; e <= 24; e++) begin
      @(posedge CLOCK_50);
      #1;
      if (out_valid === 1'b1) begin
        n_valid++;
        if (first_valid == 0) first_valid = e;
        last_out = int'(sample_out);
`ifdef BIQUAD_SAT_EN
        last_sat = int'(sat_flag);
`endif
      end
      if (busy === 1'b1) n_busy++;
      case (mode)
        1: begin
          if (e == 2) new_sample = 1'b0;
          if (e == 3) new_sample = 1'b1;
          if (e == 6) new_sample = 1'b0;
        end
        2: begin
          if (e == 3) new_sample = 1'b0;
          if (e == 6) begin
            drive_loads(rand_coef(), rand_coef(), rand_coef(), rand_coef(), rand_coef());
            new_coefficients = 1'b1;
          end
          if (e == 7) new_coefficients = 1'b0;
          if (e == 8) drive_loads(late_set[0], late_set[1], late_set[2], late_set[3], late_set[4]);
        end
        3: begin
          if (e == 3) new_sample = 1'b0;
          if (e == 4) AUD_DACLRCK = 1'b1;
          if (e == 6) AUD_DACLRCK = 1'b0;
        end
        4: begin
          if (e == 2) begin
            drive_loads(late_set[0], late_set[1], late_set[2], late_set[3], late_set[4]);
            new_coefficients = 1'b1;
          end
          if (e == 3) begin
            new_coefficients = 1'b0;
            new_sample = 1'b0;
          end
        end
        default: if (e == 3) new_sample = 1'b0;
      endcase
    end
  endtask

  initial begin
    int fv, nv, nb, exp_y;
    int fir_in[4]  = '{4000, 0, 0, 0};
    int fir_out[4] = '{1000, 1000, 1000, 0};
    int fb_out[3]  = '{1000, 1500, 1750};

    AUD_DACLRCK = 1'b1; new_sample = 1'b0; new_coefficients = 1'b0;
    sample_in = '0; drive_loads(0, 0, 0, 0, 0);
    last_out = 0; last_sat = 0;
    model_reset();

    // Held in reset with new_sample toggling: outputs stay at their reset values.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      new_sample = ~new_sample;
      check("reset_sample_out", sample_out, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
    end
    apply_reset();

    // Passthrough with latency and busy-length checks.
    load_coefs(65536, 0, 0, 0, 0);
    run_step(1000, 0, fv, nv, nb);
    check("pass_latency", fv, 9);
    check("pass_valid_count", nv, 1);
    check("pass_busy_cycles", nb, 6);
    check("pass_out", last_out, 1000);

    // FIR impulse response.
    apply_reset();
    load_coefs(16384, 16384, 16384, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_step(fir_in[i], 0, fv, nv, nb);
      check("fir_out", last_out, fir_out[i]);
    end

    // Feedback through b1 = -0.5.
    apply_reset();
    load_coefs(65536, 0, 0, -32768, 0);
    for (int i = 0; i < 3; i++) begin
      run_step(1000, 0, fv, nv, nb);
      check("feedback_out", last_out, fb_out[i]);
    end

    // Overflow: 30000 * 131071 / 65536 exceeds the sample range.
    apply_reset();
    load_coefs(131071, 0, 0, 0, 0);
    run_step(30000, 0, fv, nv, nb);
`ifdef BIQUAD_SAT_EN
    check("overflow_out", last_out, 32767);
    check("overflow_sat_flag", last_sat, 1);
`else
    check("overflow_out", last_out, -5537);
`endif

    // Collisions, against the model.
    apply_reset();
    load_coefs(rand_coef(), rand_coef(), rand_coef(), rand_coef(), rand_coef());
    exp_y = rand_sample();
    run_step(exp_y, 1, fv, nv, nb);
    exp_y = model_step(exp_y);
    check("double_edge_valid_count", nv, 1);
    check("double_edge_out", last_out, exp_y);

    for (int i = 0; i < 5; i++) late_set[i] = rand_coef();
    exp_y = rand_sample();
    run_step(exp_y, 2, fv, nv, nb);
    exp_y = model_step(exp_y);
    check("pend_load_valid_count", nv, 1);
    check("pend_load_old_set_out", last_out, exp_y);
    for (int i = 0; i < 5; i++) m_c[i] = late_set[i];
    exp_y = rand_sample();
    run_step(exp_y, 0, fv, nv, nb);
    exp_y = model_step(exp_y);
    check("pend_load_new_set_out", last_out, exp_y);

    exp_y = rand_sample();
    run_step(exp_y, 3, fv, nv, nb);
    model_reset();
    check("mid_reset_valid_count", nv, 0);
    check("mid_reset_sample_out", sample_out, 0);
    check("mid_reset_busy", busy, 0);
    run_step(12345, 0, fv, nv, nb);
    check("post_reset_zero_coef_out", last_out, model_step(12345));
    load_coefs(65536, 0, 0, -32768, 0);
    run_step(1000, 0, fv, nv, nb);
    check("post_reset_history_out", last_out, model_step(1000));

    // Randomized steps; every fifth step loads a fresh set in the same cycle as the request.
    apply_reset();
    load_coefs(rand_coef(), rand_coef(), rand_coef(), rand_coef(), rand_coef());
    for (int i = 0; i < 30; i++) begin
      int x, mode;
      x = rand_sample();
      mode = (i % 5 == 4) ? 4 : 0;
      if (mode == 4) for (int k = 0; k < 5; k++) late_set[k] = rand_coef();
      run_step(x, mode, fv, nv, nb);
      if (mode == 4) for (int k = 0; k < 5; k++) m_c[k] = late_set[k];
      exp_y = model_step(x);
      check("rand_latency", fv, 9);
      check("rand_out", last_out, exp_y);
`ifdef BIQUAD_SAT_EN
      check("rand_sat_flag", last_sat, int'(m_clamp));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
